uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous `rx` line into parallel bytes, using the oversampling tick `rx_clk_en` from the UART clock generator as its only timebase. It sits between the pad-side serial input and the host-side byte interface. It is the receive-direction counterpart of the transmitter: it detects and qualifies start bits, samples data mid-bit, and checks stop and optional parity. A one-entry holding register with a valid/ready handshake delivers each byte to the host.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter.
//   rx_state_t         : receiver FSM state encoding
//   DEFAULT_OVERSAMPLE : oversample ticks per bit used by default
//   DEFAULT_DATA_BITS  : payload bits per frame used by default
//   parity_bit()       : parity bit value for a payload (even or odd)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int MAX_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity bit that makes the total count of ones even (odd=0) or odd
  // (odd=1). Narrower payloads are zero-extended by the caller, which
  // leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. Both flops load
// RESET_VAL under reset so an idle-high line does not look like an edge.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   d    : asynchronous input
//   q    : synchronised output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: deserialises the rx line into DATA_BITS-wide words (LSB
// first) using the rx_clk_en oversample tick as its only timebase, and
// delivers them through a one-entry holding register with valid/ready.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data, parity_err is live
//   undefined : frame is start + data + stop, parity_err tied 0,
//               parity_odd ignored
//
// Parameters:
//   DATA_BITS  : payload bits per frame (5..8)
//   OVERSAMPLE : rx_clk_en ticks per bit period (even, >= 4)
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   active     : receiver enable; low forces IDLE and clears counters
//   rx_clk_en  : oversample tick, one clk wide
//   rx         : asynchronous serial line, idle high
//   parity_odd : 1 = odd parity, 0 = even parity
//   rx_data    : received word, stable while rx_valid
//   rx_valid   : word available
//   rx_ready   : host accepts the word
//   frame_err  : one-cycle pulse on a bad stop bit
//   parity_err : one-cycle pulse on a parity mismatch
//   overrun    : one-cycle pulse when a good frame is dropped (register full)
//   busy       : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // tick_cnt terminal values: the start bit is sampled half a bit in, every
  // later bit one full bit after the previous sample.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 rx_s;
  logic                 rx_prev;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif

  // Receiver FSM with all outputs registered. Error/overrun flags default
  // low every cycle so they come out as single-cycle pulses. The holding
  // register is released by the host handshake independently of the FSM;
  // a good frame finishing in the accept cycle overrides that release,
  // which is why the load condition includes rx_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      rx_prev    <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Edge detection compares against the line as seen on the previous
      // tick, so it works at any tick rate.
      if (rx_clk_en) begin
        rx_prev <= rx_s;
      end

      if (!active) begin
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        busy     <= 1'b0;
      end else if (rx_clk_en) begin
        case (state)
          IDLE: begin
            // Only a falling edge starts a frame, so a held-low break
            // line cannot retrigger the receiver.
            if (rx_prev && !rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              bit_cnt  <= '0;
              busy     <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt         <= '0;
              data_sr[bit_cnt] <= rx_s;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt   <= '0;
              parity_bad <= (rx_s != parity_bit(MAX_DATA_BITS'(data_sr), parity_odd));
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              // A bad stop bit takes precedence over a parity mismatch.
              if (!rx_s) begin
                frame_err <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              else if (parity_bad) begin
                parity_err <= 1'b1;
              end
`endif
              else if (!rx_valid || rx_ready) begin
                rx_data  <= data_sr;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with rx_clk_en tied high and OVERSAMPLE=16,
// so one clk cycle is one oversample tick and one bit lasts 16 cycles.
// Inputs change on the falling clock edge; a monitor samples outputs 2 time
// units after each rising edge and keeps running counts of pulses.
// Also builds with UART_RX_PARITY_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int OS = 16;
  // rx driven low at a falling edge: 2 synchroniser edges, then the edge
  // detect, then half a start bit plus the remaining full bits.
  localparam int LATENCY   = 3 + OS / 2 + (9 + P) * OS;
  localparam int BUSY_CYC  = OS / 2 + (9 + P) * OS;

  logic       clk = 1'b0;
  logic       rst;
  logic       active;
  logic       rx_clk_en;
  logic       rx;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int asserts  = 0;
  int failures = 0;

  int cycle           = 0;
  int validRises      = 0;
  int validHighCycles = 0;
  int lastValidCycle  = 0;
  int busyCycles      = 0;
  int frameErrs       = 0;
  int parityErrs      = 0;
  int overruns        = 0;
  logic validPrev     = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .active     (active),
    .rx_clk_en  (rx_clk_en),
    .rx         (rx),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Output monitor, sampling just after each rising edge.
  always @(posedge clk) begin
    #2;
    cycle = cycle + 1;
    if (rx_valid === 1'b1 && validPrev !== 1'b1) begin
      validRises     = validRises + 1;
      lastValidCycle = cycle;
    end
    validPrev = rx_valid;
    if (rx_valid === 1'b1)   validHighCycles = validHighCycles + 1;
    if (busy === 1'b1)       busyCycles      = busyCycles + 1;
    if (frame_err === 1'b1)  frameErrs       = frameErrs + 1;
    if (parity_err === 1'b1) parityErrs      = parityErrs + 1;
    if (overrun === 1'b1)    overruns        = overruns + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    asserts = asserts + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    rx = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic stopBit);
    applyStimulus(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(data[i], OS);
    end
`ifdef UART_RX_PARITY_EN
    applyStimulus(parBit, OS);
`else
    if (parBit) begin
      rx = 1'b1;
    end
`endif
    applyStimulus(stopBit, OS);
  endtask

  int baseCycle, baseRises, baseHigh, baseBusy, baseFerr, baseOvr, basePerr;

  task automatic snapshot();
    baseCycle = cycle;
    baseRises = validRises;
    baseHigh  = validHighCycles;
    baseBusy  = busyCycles;
    baseFerr  = frameErrs;
    baseOvr   = overruns;
    basePerr  = parityErrs;
  endtask

  initial begin
    rst        = 1'b1;
    active     = 1'b1;
    rx_clk_en  = 1'b1;
    rx         = 1'b1;
    rx_ready   = 1'b0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset rx_valid",   rx_valid,   0);
    checkOutput("reset rx_data",    rx_data,    0);
    checkOutput("reset frame_err",  frame_err,  0);
    checkOutput("reset parity_err", parity_err, 0);
    checkOutput("reset overrun",    overrun,    0);
    checkOutput("reset busy",       busy,       0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame 0xA5 with rx_ready high
    $display("[TB] good frame 0xA5");
    rx_ready = 1'b1;
    snapshot();
    sendFrame(8'hA5, 1'b0, 1'b1);
    checkOutput("a5 latency",      lastValidCycle - baseCycle, LATENCY);
    checkOutput("a5 valid rises",  validRises - baseRises, 1);
    checkOutput("a5 valid width",  validHighCycles - baseHigh, 1);
    checkOutput("a5 busy cycles",  busyCycles - baseBusy, BUSY_CYC);
    checkOutput("a5 frame_err",    frameErrs - baseFerr, 0);
    checkOutput("a5 rx_data",      rx_data, 32'hA5);
    checkOutput("a5 rx_valid end", rx_valid, 0);
    checkOutput("a5 busy end",     busy, 0);

    // 5-cycle glitch: false start
    $display("[TB] 5-tick glitch");
    snapshot();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 40);
    checkOutput("glitch busy cycles", busyCycles - baseBusy, OS / 2);
    checkOutput("glitch valid rises", validRises - baseRises, 0);
    checkOutput("glitch frame_err",   frameErrs - baseFerr, 0);
    checkOutput("glitch busy end",    busy, 0);

    // Bad stop bit on 0x3C, then break held low
    $display("[TB] bad stop bit and break");
    snapshot();
    sendFrame(8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 500);
    applyStimulus(1'b1, 40);
    checkOutput("ferr count",       frameErrs - baseFerr, 1);
    checkOutput("ferr valid rises", validRises - baseRises, 0);
    checkOutput("break busy cycles", busyCycles - baseBusy, BUSY_CYC);
    checkOutput("break busy end",    busy, 0);
    checkOutput("ferr data kept",    rx_data, 32'hA5);

    // Back-to-back 0x11 and 0x22 with rx_ready low
    $display("[TB] back-to-back overrun");
    rx_ready = 1'b0;
    snapshot();
    sendFrame(8'h11, 1'b0, 1'b1);
    sendFrame(8'h22, 1'b0, 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("ovr count",       overruns - baseOvr, 1);
    checkOutput("ovr valid rises", validRises - baseRises, 1);
    checkOutput("ovr rx_valid",    rx_valid, 1);
    checkOutput("ovr rx_data",     rx_data, 32'h11);
    checkOutput("ovr frame_err",   frameErrs - baseFerr, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput("read rx_valid",   rx_valid, 0);
    checkOutput("read rx_data",    rx_data, 32'h11);

`ifdef UART_RX_PARITY_EN
    // Odd parity on 0x01: correct parity bit is 0
    $display("[TB] parity check");
    parity_odd = 1'b1;
    snapshot();
    sendFrame(8'h01, 1'b1, 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("perr count",       parityErrs - basePerr, 1);
    checkOutput("perr valid rises", validRises - baseRises, 0);
    checkOutput("perr rx_valid",    rx_valid, 0);
    snapshot();
    sendFrame(8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("pok count",       parityErrs - basePerr, 0);
    checkOutput("pok rx_valid",    rx_valid, 1);
    checkOutput("pok rx_data",     rx_data, 32'h01);
    parity_odd = 1'b0;
    rx_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready   = 1'b0;
`endif

    // Fill the holding register, then reset mid-frame
    $display("[TB] reset mid-frame");
    sendFrame(8'hC3, 1'b0, 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("c3 rx_valid", rx_valid, 1);
    checkOutput("c3 rx_data",  rx_data, 32'hC3);
    applyStimulus(1'b0, OS);
    applyStimulus(1'b1, 3 * OS + OS / 2);
    checkOutput("pre-rst busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst rx_valid",  rx_valid, 0);
    checkOutput("rst rx_data",   rx_data, 0);
    checkOutput("rst busy",      busy, 0);
    checkOutput("rst frame_err", frame_err, 0);
    checkOutput("rst overrun",   overrun, 0);
    rst = 1'b0;
    snapshot();
    applyStimulus(1'b1, 200);
    checkOutput("post-rst busy cycles", busyCycles - baseBusy, 0);
    sendFrame(8'h5A, 1'b0, 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("5a rx_valid",  rx_valid, 1);
    checkOutput("5a rx_data",   rx_data, 32'h5A);
    checkOutput("5a frame_err", frameErrs - baseFerr, 0);

    // Drop active mid-frame: FSM idles, held word survives
    $display("[TB] active dropped mid-frame");
    snapshot();
    applyStimulus(1'b0, OS);
    applyStimulus(1'b1, 24);
    active = 1'b0;
    @(negedge clk);
    checkOutput("inactive busy",     busy, 0);
    checkOutput("inactive rx_valid", rx_valid, 1);
    checkOutput("inactive rx_data",  rx_data, 32'h5A);
    active = 1'b1;
    applyStimulus(1'b1, 200);
    checkOutput("reactive busy",    busy, 0);
    checkOutput("reactive overrun", overruns - baseOvr, 0);
    checkOutput("reactive ferr",    frameErrs - baseFerr, 0);

    checkOutput("total parity_err pulses", parityErrs, P);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
